// File: rtl/fifo_pkg.sv
// Shared definitions for the single- and dual-clock FIFO family: depth and
// level-width helpers plus the read-mode encoding.
package fifo_pkg;

  // FWFT parameter encoding, common to both FIFO variants
  localparam int unsigned FWFT_STD  = 0;
  localparam int unsigned FWFT_FALL = 1;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Occupancy needs one extra bit so that a full FIFO (DEPTH) is representable
  function automatic int unsigned fifo_lvl_w(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write on wclk, combinational read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  wclk,
  input  logic                  wclken,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge wclk) begin
    if (wclken) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: binary pointers, registered occupancy and flags,
// sticky overflow/underflow, synchronous flush and selectable fall-through read.
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned LVL_W = fifo_lvl_w(ADDR_WIDTH);

  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_THRESH);
  localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_THRESH);

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1) begin : g_bad_afull
    $error("sync_fifo_ctl: AFULL_THRESH=%0d outside 1..%0d", AFULL_THRESH, DEPTH - 1);
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_ctl: AEMPTY_THRESH=%0d outside 0..%0d", AEMPTY_THRESH, DEPTH - 1);
  end
  if (FWFT != FWFT_STD && FWFT != FWFT_FALL) begin : g_bad_fwft
    $error("sync_fifo_ctl: FWFT=%0d is not a valid read mode", FWFT);
  end

  logic [LVL_W-1:0] wptr_q, wptr_d;
  logic [LVL_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wfull_q, wfull_d;
  logic             afull_q, afull_d;
  logic             rempty_q, rempty_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Acceptance uses the registered flags, so a full FIFO lets the read win
  // and an empty FIFO lets the write win when both are requested.
  assign wr_acc = winc & ~wfull_q;
  assign rd_acc = rinc & ~rempty_q;
  assign mem_we = wr_acc & ~clr;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      wptr_d  = wptr_q + LVL_W'(wr_acc);
      rptr_d  = rptr_q + LVL_W'(rd_acc);
      level_d = level_q + LVL_W'(wr_acc) - LVL_W'(rd_acc);
      ovf_d   = ovf_q | (winc & wfull_q);
      udf_d   = udf_q | (rinc & rempty_q);
    end
  end

  always_comb begin
    wfull_d  = (level_d == DEPTH_L);
    afull_d  = (level_d >= AFULL_L);
    rempty_d = (level_d == '0);
    aempty_d = (level_d <= AEMPTY_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      afull_q  <= 1'b0;
      rempty_q <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      wfull_q  <= wfull_d;
      afull_q  <= afull_d;
      rempty_q <= rempty_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .wclk   (clk),
    .wclken (mem_we),
    .waddr  (wptr_q[ADDR_WIDTH-1:0]),
    .wdata  (wdata),
    .raddr  (rptr_q[ADDR_WIDTH-1:0]),
    .rdata  (mem_rdata)
  );

  if (FWFT == FWFT_FALL) begin : g_fwft
    // Head word is presented combinationally; zero while empty keeps reset value clean
    assign rdata = rempty_q ? '0 : mem_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (clr) begin
        rdata_d = '0;
      end else if (rd_acc) begin
        rdata_d = mem_rdata;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata = rdata_q;
  end

  assign wfull         = wfull_q;
  assign walmost_full  = afull_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = aempty_q;
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

`ifndef SYNTHESIS
  a_level_matches_ptrs : assert property (@(posedge clk) disable iff (!rst_n)
    (LVL_W'(wptr_q - rptr_q) == level_q));
  a_level_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    (level_q <= DEPTH_L));
  a_full_empty_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(wfull_q && rempty_q));
`endif

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl: a standard-mode instance checked every cycle
// against a queue model, plus a fall-through instance for the FWFT read path.
module tb_sync_fifo_ctl;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n;

  logic          clr0, winc0, rinc0;
  logic [DW-1:0] wdata0, rdata0;
  logic          wfull0, afull0, rempty0, aempty0, ovf0, udf0;
  logic [AW:0]   level0;

  logic          clr1, winc1, rinc1;
  logic [DW-1:0] wdata1, rdata1;
  logic          wfull1, afull1, rempty1, aempty1, ovf1, udf1;
  logic [AW:0]   level1;

  sync_fifo_ctl #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .FWFT (0),
    .AFULL_THRESH (AF), .AEMPTY_THRESH (AE)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .clr (clr0),
    .winc (winc0), .wdata (wdata0), .wfull (wfull0), .walmost_full (afull0),
    .rinc (rinc0), .rdata (rdata0), .rempty (rempty0), .ralmost_empty (aempty0),
    .level (level0), .overflow (ovf0), .underflow (udf0)
  );

  sync_fifo_ctl #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .FWFT (1),
    .AFULL_THRESH (AF), .AEMPTY_THRESH (AE)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .clr (clr1),
    .winc (winc1), .wdata (wdata1), .wfull (wfull1), .walmost_full (afull1),
    .rinc (rinc1), .rdata (rdata1), .rempty (rempty1), .ralmost_empty (aempty1),
    .level (level1), .overflow (ovf1), .underflow (udf1)
  );

  always #5 clk = ~clk;

  int unsigned   n_chk  = 0;
  int unsigned   n_fail = 0;

  logic [DW-1:0] sb[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_rdata = '0;
  endtask

  task automatic check_state(input string where);
    int lvl;
    lvl = sb.size();
    chk($sformatf("%s.level", where),         32'(level0),  32'(lvl));
    chk($sformatf("%s.wfull", where),         32'(wfull0),  32'(lvl == DEPTH));
    chk($sformatf("%s.walmost_full", where),  32'(afull0),  32'(lvl >= AF));
    chk($sformatf("%s.rempty", where),        32'(rempty0), 32'(lvl == 0));
    chk($sformatf("%s.ralmost_empty", where), 32'(aempty0), 32'(lvl <= AE));
    chk($sformatf("%s.overflow", where),      32'(ovf0),    32'(m_ovf));
    chk($sformatf("%s.underflow", where),     32'(udf0),    32'(m_udf));
    chk($sformatf("%s.rdata", where),         32'(rdata0),  32'(m_rdata));
  endtask

  // One clock of stimulus on dut0; the model decides acceptance from its pre-edge state
  task automatic step(input string where, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c);
    int  lvl;
    bit  wacc, racc;
    lvl  = sb.size();
    wacc = w && !c && (lvl != DEPTH);
    racc = r && !c && (lvl != 0);
    winc0 = w; wdata0 = d; rinc0 = r; clr0 = c;
    @(posedge clk);
    #1;
    winc0 = 1'b0; rinc0 = 1'b0; clr0 = 1'b0;
    if (c) begin
      model_reset();
    end else begin
      if (w && lvl == DEPTH) m_ovf = 1'b1;
      if (r && lvl == 0)     m_udf = 1'b1;
      if (racc) m_rdata = sb.pop_front();
      if (wacc) sb.push_back(d);
    end
    check_state(where);
  endtask

  initial begin
    rst_n = 1'b1;
    clr0 = 1'b0; winc0 = 1'b0; rinc0 = 1'b0; wdata0 = '0;
    clr1 = 1'b0; winc1 = 1'b0; rinc1 = 1'b0; wdata1 = '0;
    model_reset();

    // Power-on reset, observed asynchronously before the first clock edge
    #2 rst_n = 1'b0;
    #1 check_state("reset");
    chk("reset.fwft_rempty", 32'(rempty1), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: fill then drain
    step("fill1", 1'b1, 8'h11, 1'b0, 1'b0);
    step("fill2", 1'b1, 8'h22, 1'b0, 1'b0);
    step("fill3", 1'b1, 8'h33, 1'b0, 1'b0);
    step("fill4", 1'b1, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step($sformatf("drain%0d", i), 1'b0, '0, 1'b1, 1'b0);

    // 2: overflow drops data and stays sticky
    step("ovf_w1", 1'b1, 8'h11, 1'b0, 1'b0);
    step("ovf_w2", 1'b1, 8'h22, 1'b0, 1'b0);
    step("ovf_w3", 1'b1, 8'h33, 1'b0, 1'b0);
    step("ovf_w4", 1'b1, 8'h44, 1'b0, 1'b0);
    step("ovf_w5", 1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step($sformatf("ovf_rd%0d", i), 1'b0, '0, 1'b1, 1'b0);

    // 3: simultaneous read/write at mid level, then at full
    step("sim_pre1", 1'b1, 8'hA0, 1'b0, 1'b0);
    step("sim_pre2", 1'b1, 8'hA1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step($sformatf("sim_rw%0d", i), 1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
    step("sim_fill1", 1'b1, 8'hC0, 1'b0, 1'b0);
    step("sim_fill2", 1'b1, 8'hC1, 1'b0, 1'b0);
    step("sim_full_rw", 1'b1, 8'hC2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("sim_drain%0d", i), 1'b0, '0, 1'b1, 1'b0);

    // 4: underflow on empty, then write+read when empty
    step("udf_rd", 1'b0, '0, 1'b1, 1'b0);
    step("empty_rw", 1'b1, 8'hD0, 1'b1, 1'b0);
    step("empty_rw_drain", 1'b0, '0, 1'b1, 1'b0);

    // 5: fall-through instance shows the head word without rinc
    winc1 = 1'b1; wdata1 = 8'hA5;
    @(posedge clk); #1;
    winc1 = 1'b0;
    chk("fwft.rempty_after_wr", 32'(rempty1), 32'd0);
    chk("fwft.rdata_head",      32'(rdata1),  32'hA5);
    chk("fwft.level",           32'(level1),  32'd1);
    @(posedge clk); #1;
    chk("fwft.rdata_hold",      32'(rdata1),  32'hA5);
    rinc1 = 1'b1;
    @(posedge clk); #1;
    rinc1 = 1'b0;
    chk("fwft.rempty_after_rd", 32'(rempty1), 32'd1);
    chk("fwft.level_after_rd",  32'(level1),  32'd0);

    // 6: flush beats a concurrent write
    step("clr_w1", 1'b1, 8'hE0, 1'b0, 1'b0);
    step("clr_w2", 1'b1, 8'hE1, 1'b0, 1'b0);
    step("clr_w3", 1'b1, 8'hE2, 1'b0, 1'b0);
    step("clr_rd", 1'b0, '0, 1'b1, 1'b0);
    step("clr_w4", 1'b1, 8'hE3, 1'b0, 1'b0);
    step("clr_hit", 1'b1, 8'hEE, 1'b0, 1'b1);
    step("clr_after", 1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of traffic
    step("arst_w1", 1'b1, 8'hF0, 1'b0, 1'b0);
    step("arst_w2", 1'b1, 8'hF1, 1'b0, 1'b0);
    step("arst_rd", 1'b0, '0, 1'b1, 1'b0);
    winc0 = 1'b1; wdata0 = 8'hF2; winc1 = 1'b1; wdata1 = 8'h5A;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("arst");
    chk("arst.fwft_rempty", 32'(rempty1), 32'd1);
    chk("arst.fwft_level",  32'(level1),  32'd0);
    winc0 = 1'b0; winc1 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Pointer wrap: 3x DEPTH words streamed through
    step("wrap_pre1", 1'b1, 8'h60, 1'b0, 1'b0);
    step("wrap_pre2", 1'b1, 8'h61, 1'b0, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++)
      step($sformatf("wrap_rw%0d", i), 1'b1, 8'h70 + 8'(i), 1'b1, 1'b0);
    step("wrap_drain1", 1'b0, '0, 1'b1, 1'b0);
    step("wrap_drain2", 1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
